// File: rtl/mips_mem_pkg.sv
// Shared memory-stage constants for the MIPS32 load/store paths:
// access size encodings, error codes and the store FSM state type.
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10,
      ST_ERR  = 2'b11
   } mem_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational store narrowing: replicates byte/half data onto all lanes,
// produces little-endian byte enables and flags misaligned accesses.
module store_lane_gen
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misaligned
);

   always_comb begin
      wdata      = data;
      be         = 4'b1111;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << addr_lo;
         end
         SZ_HALF: begin
            wdata      = {2{data[15:0]}};
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            misaligned = addr_lo[0];
         end
         // word and the reserved encoding share one path
         default: misaligned = |addr_lo;
      endcase
   end

endmodule

// File: rtl/store_narrow_unit.sv
// MEM-stage store path: captures a store, drives one outstanding write
// request to data memory and reports completion, misalignment or timeout.
module store_narrow_unit
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        st_done,
   output logic        st_err,
   output logic [1:0]  err_code,
   output logic [31:0] err_addr
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic TO_EN = (TIMEOUT != 0);

   mem_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q;
   logic [31:0]      lane_wdata;
   logic [3:0]       lane_be;
   logic             lane_mis;
   logic             accept;
   logic             expire;

   store_lane_gen u_lane (
      .size       (st_size),
      .addr_lo    (st_addr[1:0]),
      .data       (st_data),
      .wdata      (lane_wdata),
      .be         (lane_be),
      .misaligned (lane_mis)
   );

   assign accept = (state == ST_IDLE) && st_valid;
   assign expire = TO_EN && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // an ack in the expiry cycle still completes the store
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (st_valid) state_nx = lane_mis ? ST_ERR : ST_REQ;
         ST_REQ: begin
            if (mem_ack)     state_nx = ST_DONE;
            else if (expire) state_nx = ST_ERR;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_ready  <= 1'b1;
         mem_req   <= 1'b0;
         st_done   <= 1'b0;
         st_err    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         addr_q    <= '0;
         cnt       <= '0;
         err_code  <= ERR_NONE;
         err_addr  <= '0;
      end else begin
         st_ready <= (state_nx == ST_IDLE);
         mem_req  <= (state_nx == ST_REQ);
         st_done  <= (state_nx == ST_DONE);
         st_err   <= (state_nx == ST_ERR);

         if (accept) begin
            addr_q    <= st_addr;
            mem_addr  <= word_align(st_addr);
            mem_wdata <= lane_wdata;
            mem_be    <= lane_be;
            cnt       <= '0;
         end else if (state == ST_REQ && TO_EN) begin
            cnt <= cnt + 1'b1;
         end

         // err_code/err_addr are sticky between faults
         if (accept && lane_mis) begin
            err_code <= ERR_MISALIGN;
            err_addr <= st_addr;
         end else if (state == ST_REQ && !mem_ack && expire) begin
            err_code <= ERR_TIMEOUT;
            err_addr <= addr_q;
         end
      end
   end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: directed scenarios plus
// randomized stores compared against a size/alignment reference model.
module tb_store_narrow_unit;
   import mips_mem_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [1:0]  st_size = 2'b00;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic        st_done;
   logic        st_err;
   logic [1:0]  err_code;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   store_narrow_unit #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_size   (st_size),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .st_done   (st_done),
      .st_err    (st_err),
      .err_code  (err_code),
      .err_addr  (err_addr)
   );

   typedef struct {
      int          req_cycles;
      bit          stable;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          done_cnt;
      int          err_cnt;
      int          done_at;
      int          err_at;
      int          ready_at;
      logic [1:0]  code;
      logic [31:0] eaddr;
      bit          timed_out;
   } obs_t;

   // Reference: access width in bytes decides lanes, replication and alignment
   function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] wd, output logic [3:0] be, output bit mis);
      int nb;
      int lane;
      nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      mis  = (a % nb) != 0;
      lane = int'(a % 4);
      lane = lane - (lane % nb);
      be   = 4'(((1 << nb) - 1) << lane);
      if (nb == 1)      wd = {24'h0, d[7:0]} * 32'h0101_0101;
      else if (nb == 2) wd = {16'h0, d[15:0]} * 32'h0001_0001;
      else              wd = d;
   endfunction

   // Issues one store at a negedge and records what the DUT does until ready again.
   // ack_wait < 0 means memory never acknowledges.
   task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int ack_wait, input bit junk, output obs_t o);
      int w;
      o = '{default: 0};
      w = 0;
      while (!st_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!st_ready) begin
         o.timed_out = 1'b1;
         return;
      end
      st_valid = 1'b1;
      st_size  = sz;
      st_addr  = a;
      st_data  = d;
      @(negedge clk);
      st_valid    = junk;
      st_size     = 2'($urandom);
      st_addr     = $urandom;
      st_data     = $urandom;
      o.stable    = 1'b1;
      o.timed_out = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (mem_req) begin
            if (o.req_cycles == 0) begin
               o.addr  = mem_addr;
               o.wdata = mem_wdata;
               o.be    = mem_be;
            end else if ({mem_addr, mem_wdata, mem_be} !== {o.addr, o.wdata, o.be}) begin
               o.stable = 1'b0;
            end
            mem_ack = (o.req_cycles == ack_wait);
            o.req_cycles++;
         end else begin
            mem_ack = 1'b0;
         end
         if (st_done) begin
            o.done_cnt++;
            o.done_at = c + 1;
         end
         if (st_err) begin
            o.err_cnt++;
            o.err_at = c + 1;
            o.code   = err_code;
            o.eaddr  = err_addr;
         end
         if (st_done || st_err) st_valid = 1'b0;
         if (st_ready) begin
            o.ready_at  = c + 1;
            o.timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      mem_ack  = 1'b0;
      st_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({st_ready, mem_req, st_done, st_err, err_code, mem_be} !== 10'b1_0_0_0_00_0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rdy=%b req=%b done=%b err=%b code=%b be=%b, want 1 0 0 0 00 0000",
                  st_ready, mem_req, st_done, st_err, err_code, mem_be);
      end
      n_checks++;
      if ({mem_addr, mem_wdata, err_addr} !== 96'h0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h wdata=%h eaddr=%h, want all 0", mem_addr, mem_wdata, err_addr);
      end
   endtask

   task automatic test_byte();
      obs_t o;
      run_store(SZ_BYTE, 32'h0000_1003, 32'hDEAD_BEEF, 1, 1'b0, o);
      n_checks++;
      if ({o.addr, o.wdata, o.be} !== {32'h0000_1000, 32'hEFEF_EFEF, 4'b1000}) begin
         n_fail++;
         $display("FAIL byte_lanes: got addr=%h wdata=%h be=%b, want 00001000 efefefef 1000", o.addr, o.wdata, o.be);
      end
      n_checks++;
      if (o.timed_out || o.done_cnt != 1 || o.err_cnt != 0 || o.done_at != 3 || o.req_cycles != 2) begin
         n_fail++;
         $display("FAIL byte_done: got to=%0d done=%0d err=%0d done_at=%0d req=%0d, want 0 1 0 3 2",
                  o.timed_out, o.done_cnt, o.err_cnt, o.done_at, o.req_cycles);
      end
   endtask

   task automatic test_half_wait();
      obs_t o;
      run_store(SZ_HALF, 32'h0000_2002, 32'h1234_ABCD, 3, 1'b1, o);
      n_checks++;
      if ({o.addr, o.wdata, o.be} !== {32'h0000_2000, 32'hABCD_ABCD, 4'b1100}) begin
         n_fail++;
         $display("FAIL half_lanes: got addr=%h wdata=%h be=%b, want 00002000 abcdabcd 1100", o.addr, o.wdata, o.be);
      end
      n_checks++;
      if (o.req_cycles != 4 || !o.stable) begin
         n_fail++;
         $display("FAIL half_hold: got req_cycles=%0d stable=%0d, want 4 1", o.req_cycles, o.stable);
      end
      n_checks++;
      if (o.timed_out || o.done_cnt != 1 || o.err_cnt != 0 || o.done_at != 5) begin
         n_fail++;
         $display("FAIL half_done: got to=%0d done=%0d err=%0d done_at=%0d, want 0 1 0 5",
                  o.timed_out, o.done_cnt, o.err_cnt, o.done_at);
      end
   endtask

   task automatic test_misalign();
      obs_t o;
      run_store(SZ_WORD, 32'h0000_3001, 32'h5555_AAAA, 0, 1'b0, o);
      n_checks++;
      if (o.timed_out || o.err_cnt != 1 || o.done_cnt != 0 || o.err_at != 1 || o.req_cycles != 0) begin
         n_fail++;
         $display("FAIL mis_pulse: got to=%0d err=%0d done=%0d err_at=%0d req=%0d, want 0 1 0 1 0",
                  o.timed_out, o.err_cnt, o.done_cnt, o.err_at, o.req_cycles);
      end
      n_checks++;
      if (o.code !== ERR_MISALIGN || o.eaddr !== 32'h0000_3001) begin
         n_fail++;
         $display("FAIL mis_info: got code=%b addr=%h, want 01 00003001", o.code, o.eaddr);
      end
      run_store(SZ_BYTE, 32'h0000_0010, 32'h0000_0077, 0, 1'b0, o);
      n_checks++;
      if (o.done_cnt != 1 || err_code !== ERR_MISALIGN || err_addr !== 32'h0000_3001) begin
         n_fail++;
         $display("FAIL err_hold: got done=%0d code=%b addr=%h, want 1 01 00003001", o.done_cnt, err_code, err_addr);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      run_store(SZ_WORD, 32'h0000_4000, 32'hCAFE_F00D, -1, 1'b0, o);
      n_checks++;
      if (o.timed_out || o.req_cycles != TO || o.err_cnt != 1 || o.done_cnt != 0 || o.err_at != TO + 1) begin
         n_fail++;
         $display("FAIL tmo_pulse: got to=%0d req=%0d err=%0d done=%0d err_at=%0d, want 0 %0d 1 0 %0d",
                  o.timed_out, o.req_cycles, o.err_cnt, o.done_cnt, o.err_at, TO, TO + 1);
      end
      n_checks++;
      if (o.code !== ERR_TIMEOUT || o.eaddr !== 32'h0000_4000) begin
         n_fail++;
         $display("FAIL tmo_info: got code=%b addr=%h, want 10 00004000", o.code, o.eaddr);
      end
   endtask

   task automatic test_ack_tie();
      obs_t o;
      run_store(SZ_WORD, 32'h0000_4100, 32'h0BAD_F00D, TO - 1, 1'b0, o);
      n_checks++;
      if (o.timed_out || o.done_cnt != 1 || o.err_cnt != 0 || o.done_at != TO + 1 || o.req_cycles != TO) begin
         n_fail++;
         $display("FAIL ack_tie: got to=%0d done=%0d err=%0d done_at=%0d req=%0d, want 0 1 0 %0d %0d",
                  o.timed_out, o.done_cnt, o.err_cnt, o.done_at, o.req_cycles, TO + 1, TO);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      run_store(SZ_RSVD, 32'h0000_0008, 32'h1357_9BDF, 0, 1'b0, o);
      n_checks++;
      if ({o.addr, o.wdata, o.be} !== {32'h0000_0008, 32'h1357_9BDF, 4'b1111} || o.done_cnt != 1) begin
         n_fail++;
         $display("FAIL rsvd_word: got addr=%h wdata=%h be=%b done=%0d, want 00000008 13579bdf 1111 1",
                  o.addr, o.wdata, o.be, o.done_cnt);
      end
      n_checks++;
      if (o.ready_at != 3 || o.done_at != 2) begin
         n_fail++;
         $display("FAIL zero_wait_rate: got done_at=%0d ready_at=%0d, want 2 3", o.done_at, o.ready_at);
      end
      run_store(SZ_RSVD, 32'h0000_0006, 32'h2468_ACE0, 0, 1'b0, o);
      n_checks++;
      if (o.err_cnt != 1 || o.req_cycles != 0 || o.code !== ERR_MISALIGN) begin
         n_fail++;
         $display("FAIL rsvd_mis: got err=%0d req=%0d code=%b, want 1 0 01", o.err_cnt, o.req_cycles, o.code);
      end
   endtask

   task automatic test_ack_idle();
      int bad;
      bad = 0;
      mem_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (!st_ready || mem_req || st_done || st_err) bad++;
      end
      mem_ack = 1'b0;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL ack_idle: got %0d disturbed cycles, want 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int   pulses;
      st_valid = 1'b1;
      st_size  = SZ_WORD;
      st_addr  = 32'h0000_7000;
      st_data  = 32'h7777_7777;
      @(negedge clk);
      st_valid = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_req: got mem_req=%b, want 1", mem_req);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || st_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_drop: got mem_req=%b st_ready=%b, want 0 1", mem_req, st_ready);
      end
      pulses = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (st_done || st_err || mem_req) pulses++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (st_done || st_err || mem_req) pulses++;
      n_checks++;
      if (pulses != 0 || st_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_quiet: got %0d pulse cycles, st_ready=%b, want 0 1", pulses, st_ready);
      end
      run_store(SZ_BYTE, 32'h0000_0000, 32'h0000_005A, 0, 1'b0, o);
      n_checks++;
      if (o.done_cnt != 1 || o.err_cnt != 0 || o.be !== 4'b0001 || o.wdata !== 32'h5A5A_5A5A) begin
         n_fail++;
         $display("FAIL rst_recover: got done=%0d err=%0d be=%b wdata=%h, want 1 0 0001 5a5a5a5a",
                  o.done_cnt, o.err_cnt, o.be, o.wdata);
      end
   endtask

   task automatic test_random();
      obs_t        o;
      logic [1:0]  sz;
      logic [31:0] a, d, ewd;
      logic [3:0]  ebe;
      bit          mis;
      int          aw;
      for (int i = 0; i < 60; i++) begin
         sz = 2'($urandom);
         a  = $urandom;
         d  = $urandom;
         aw = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 1));
         model(sz, a, d, ewd, ebe, mis);
         run_store(sz, a, d, aw, $urandom_range(0, 1) == 1, o);
         n_checks++;
         if (mis) begin
            if (o.timed_out || o.err_cnt != 1 || o.done_cnt != 0 || o.req_cycles != 0 ||
                o.err_at != 1 || o.code !== ERR_MISALIGN || o.eaddr !== a) begin
               n_fail++;
               $display("FAIL rnd%0d mis sz=%b a=%h: got err=%0d done=%0d req=%0d at=%0d code=%b ea=%h, want 1 0 0 1 01 %h",
                        i, sz, a, o.err_cnt, o.done_cnt, o.req_cycles, o.err_at, o.code, o.eaddr, a);
            end
         end else if (aw >= 0 && aw < TO) begin
            if (o.timed_out || o.done_cnt != 1 || o.err_cnt != 0 || o.req_cycles != aw + 1 ||
                o.done_at != aw + 2 || !o.stable) begin
               n_fail++;
               $display("FAIL rnd%0d done sz=%b a=%h w=%0d: got done=%0d err=%0d req=%0d at=%0d stable=%0d, want 1 0 %0d %0d 1",
                        i, sz, a, aw, o.done_cnt, o.err_cnt, o.req_cycles, o.done_at, o.stable, aw + 1, aw + 2);
            end
            n_checks++;
            if ({o.addr, o.wdata, o.be} !== {a & 32'hFFFF_FFFC, ewd, ebe}) begin
               n_fail++;
               $display("FAIL rnd%0d lanes sz=%b a=%h d=%h: got %h %h %b, want %h %h %b",
                        i, sz, a, d, o.addr, o.wdata, o.be, a & 32'hFFFF_FFFC, ewd, ebe);
            end
         end else begin
            if (o.timed_out || o.err_cnt != 1 || o.done_cnt != 0 || o.req_cycles != TO ||
                o.err_at != TO + 1 || o.code !== ERR_TIMEOUT || o.eaddr !== a) begin
               n_fail++;
               $display("FAIL rnd%0d tmo sz=%b a=%h w=%0d: got err=%0d done=%0d req=%0d at=%0d code=%b ea=%h, want 1 0 %0d %0d 10 %h",
                        i, sz, a, aw, o.err_cnt, o.done_cnt, o.req_cycles, o.err_at, o.code, o.eaddr, TO, TO + 1, a);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_byte();
      test_half_wait();
      test_misalign();
      test_timeout();
      test_ack_tie();
      test_back_to_back();
      test_ack_idle();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
